// File: rtl/sum_acc_pkg.sv
// Shared definitions for the batch sum accumulator: FSM state encoding and operand width.
package sum_acc_pkg;
    localparam int OPND_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/sum_acc_ctrl.sv
// Batch sequencing for sum_accumulator: IDLE/ACCUM/DONE FSM plus the per-batch operand counter.
module sum_acc_ctrl
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic start,
    output logic accept,
    output logic finish
);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        // Held low while reset is asserted so nothing is offered before release.
        in_ready = rst_n && (state_q != ST_DONE);
        accept   = in_valid && in_ready && !clr;
        start    = accept && (state_q == ST_IDLE);
        finish   = accept && (state_q == ST_ACCUM) && (count_q == CNT_W'(N_SAMPLES - 1));

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = CNT_W'(1);
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (finish) begin
                    count_d = '0;
                    state_d = ST_DONE;
                end else if (accept) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            state_d = ST_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
endmodule

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES {co,sum} adder results per batch with a sticky overflow flag.
// Optional macro SUM_ACC_SATURATE_EN clamps the accumulator instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [15:0]      sum,
    input  logic             co,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SUM_W = ACC_W + 1;

    logic              start, accept, finish;
    logic [OPND_W-1:0] opnd;
    logic [SUM_W-1:0]  add_full;
    logic              add_ovf;
    logic [ACC_W-1:0]  add_res;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
    logic              ovf_q, ovf_d;

    sum_acc_ctrl #(.N_SAMPLES(N_SAMPLES)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .start     (start),
        .accept    (accept),
        .finish    (finish)
    );

    assign opnd = {co, sum};

    always_comb begin
        add_full = SUM_W'(acc_q) + SUM_W'(opnd);
        add_ovf  = add_full[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
        // Once clamped at all-ones, any nonzero operand overflows again and stays clamped.
        add_res  = add_ovf ? '1 : add_full[ACC_W-1:0];
`else
        add_res  = add_full[ACC_W-1:0];
`endif
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        acc_out_d = acc_out_q;

        if (start) begin
            acc_d = ACC_W'(opnd);
            ovf_d = 1'b0;
        end else if (accept) begin
            acc_d = add_res;
            ovf_d = ovf_q | add_ovf;
        end
        if (finish) acc_out_d = add_res;

        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign acc_out = acc_out_q;
    assign ovf     = ovf_q;
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 8, meaning adder results summed per batch (legal range 2..256).
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning accumulator width in bits (legal range >= 17).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit, synchronous batch abort.
REQ-006 The block SHALL have port sum, input, 16 bits, adder sum result.
REQ-007 The block SHALL have port co, input, 1 bit, adder carry-out; operand value = {co,sum}, 17 bits unsigned.
REQ-008 The block SHALL have port in_valid, input, 1 bit, upstream operand valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, block can accept an operand.
REQ-010 The block SHALL have port acc_out, output, ACC_W bits, completed batch total.
REQ-011 The block SHALL have port ovf, output, 1 bit, batch exceeded 2^ACC_W-1 at least once.
REQ-012 The block SHALL have port out_valid, output, 1 bit, acc_out and ovf valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream accepts the result.

Function
REQ-014 An operand SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-015 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-017 In IDLE, an accepted operand SHALL load acc={co,sum} zero-extended, set count=1, clear ovf and go to ACCUM.
REQ-018 In ACCUM, an accepted operand SHALL add {co,sum} to acc and increment count.
REQ-019 The operand that makes count equal N_SAMPLES SHALL cause a transition to DONE with acc_out=final total and out_valid=1 registered on that edge (latency 1 cycle from the last accept).
REQ-020 In DONE, acc_out, ovf and out_valid SHALL hold until out_valid=1 and out_ready=1 in the same cycle; the next state SHALL then be IDLE with out_valid=0.
REQ-021 An input presented in the cycle DONE is left SHALL NOT be accepted (in_ready=0 that cycle); it is accepted from IDLE on the following cycle.
REQ-022 Any addition whose true result exceeds 2^ACC_W-1 SHALL set ovf, sticky until the next batch starts.
REQ-023 When clr=1, the next state SHALL be IDLE with out_valid=0, count=0 and acc=0, in any state; clr SHALL override a simultaneous accept or output handshake.
REQ-024 Cycles with in_valid=0 in ACCUM SHALL leave acc and count unchanged (no timeout).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, acc=0, count=0, acc_out=0, ovf=0 and out_valid=0.
REQ-026 in_ready SHALL be 1 from the first cycle after reset deassertion.
REQ-027 Reset deassertion SHALL be synchronised by the integrator; the block adds no synchroniser.

Configuration
REQ-028 With macro SUM_ACC_SATURATE_EN defined, an overflowing addition SHALL clamp acc to 2^ACC_W-1, and later additions in that batch SHALL keep it clamped.
REQ-029 Without SUM_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; ovf behaves identically in both builds.

Structure
REQ-030 A shared package sum_acc_pkg SHALL hold the FSM state encoding and the operand width constant (17).
REQ-031 The FSM and the counter SHALL live in sub-module sum_acc_ctrl; the datapath (adder, saturate/wrap and registers) SHALL stay in sum_accumulator.

Verification
REQ-032 Bench SHALL check: N=8, ACC_W=24, eight back-to-back operands {co=1,sum=0xFFFF}, out_ready=1 -> acc_out=0x0FFFF8, ovf=0, out_valid asserted 1 cycle after the 8th accept for exactly 1 cycle.
REQ-033 Bench SHALL check: N=2, ACC_W=17, operands 0x1FFFF then 0x00001 -> ovf=1, acc_out=0x00000 without the macro and 0x1FFFF with SUM_ACC_SATURATE_EN.
REQ-034 Bench SHALL check backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, acc_out and ovf stable, no operand lost; release -> IDLE, next operand accepted.
REQ-035 Bench SHALL check: clr=1 after 3 of 8 operands -> out_valid never asserts; the next batch of eight operands of 0x00010 gives acc_out=0x000080.
REQ-036 Bench SHALL check: rst_n pulsed low mid-ACCUM (asynchronously, not on a clock edge) -> all outputs 0 immediately, in_ready=1 on the first edge after release.
REQ-037 Bench SHALL check: in_valid toggled randomly with gaps -> total equals the sum of the accepted operands only.
